serial_io_controller: RTL

//  Memory-mapped serial I/O controller between the processor's load/store path
//  (data memory I/O window) and the external byte-serial port. Buffers received
//  and outgoing bytes in RX/TX FIFOs, sequences the external valid/ready

---
 rtl/serial_io_controller_if.sv | 32 +++
 rtl/serial_io_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_io_controller_if.sv
// Bus bundle for the serial I/O controller: CPU load/store window plus the
// external byte-serial port.
// Handshakes: a byte moves on a rising edge only when its valid and its
// ready/enable are both high in that cycle (serial_valid_in & serial_rden_out
// on RX; serial_wren_out is a one-cycle strobe qualified by serial_ready_in on TX).
interface serial_io_controller_if;
  logic        io_sel;
  logic [1:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_stall;
  logic [7:0]  serial_in;
  logic        serial_valid_in;
  logic        serial_rden_out;
  logic        serial_ready_in;
  logic [7:0]  serial_out;
  logic        serial_wren_out;

  modport slave (
    input  io_sel, io_addr, io_rd, io_wr, io_wdata,
    input  serial_in, serial_valid_in, serial_ready_in,
    output io_rdata, io_stall, serial_rden_out, serial_out, serial_wren_out
  );

  modport master (
    output io_sel, io_addr, io_rd, io_wr, io_wdata,
    output serial_in, serial_valid_in, serial_ready_in,
    input  io_rdata, io_stall, serial_rden_out, serial_out, serial_wren_out
  );
endinterface

// File: rtl/serial_io_controller.sv
// Memory-mapped serial I/O controller: RX/TX byte FIFOs behind a 4-register
// window, with a 3-state transmit sequencer and CPU stall on blocking accesses.
module serial_io_controller #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  serial_io_controller_if.slave  bus,
  output logic [1:0]             tx_state_dbg
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  tx_state_t tx_state, tx_state_next;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count;

  logic [7:0]  serial_out_q;
  logic        serial_wren_q;
  logic [31:0] rdata;
  logic [31:0] status_word;

  logic rx_rd, tx_wr, ctrl_wr, flush_rx, flush_tx;
  logic rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_head, tx_head;
  logic unused_wdata;

  assign rx_rd    = bus.io_sel && bus.io_rd && (bus.io_addr == 2'd0);
  assign tx_wr    = bus.io_sel && bus.io_wr && (bus.io_addr == 2'd1);
  assign ctrl_wr  = bus.io_sel && bus.io_wr && (bus.io_addr == 2'd3);
  assign flush_rx = ctrl_wr && bus.io_wdata[0];
  assign flush_tx = ctrl_wr && bus.io_wdata[1];
  assign unused_wdata = ^bus.io_wdata[31:8];

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_idle  = tx_empty && (tx_state == TX_IDLE);
  assign rx_head  = rx_mem[rx_rd_ptr];
  assign tx_head  = tx_mem[tx_rd_ptr];

  // A flush in progress closes the RX door so nothing lands in a FIFO being cleared.
  assign bus.serial_rden_out = !reset && !rx_full && !flush_rx;
  assign rx_push = bus.serial_valid_in && bus.serial_rden_out;
  assign rx_pop  = rx_rd && !rx_empty;
  assign tx_push = tx_wr && !tx_full;

  assign bus.io_stall = !reset && ((rx_rd && rx_empty) || (tx_wr && tx_full));

  assign status_word = {8'd0, 8'(tx_count), 8'(rx_count), 5'd0, tx_idle, tx_full, rx_empty};

  always_comb begin
    rdata = '0;
    if (!reset && bus.io_sel && bus.io_rd) begin
      case (bus.io_addr)
        2'd0:    rdata = {24'd0, rx_head};
        2'd2:    rdata = status_word;
        default: rdata = '0;
      endcase
    end
  end
  assign bus.io_rdata = rdata;

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.serial_in;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.io_wdata[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (flush_rx) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (flush_tx) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // A flush blocks a new start, but a byte already strobed runs SEND -> GAP.
  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && bus.serial_ready_in && !flush_tx) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_SEND;
        end
      end
      TX_SEND: tx_state_next = TX_GAP;
      TX_GAP:  tx_state_next = TX_IDLE;
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_out_q  <= 8'd0;
      serial_wren_q <= 1'b0;
    end else begin
      serial_wren_q <= tx_pop;
      if (tx_pop) serial_out_q <= tx_head;
    end
  end

  assign bus.serial_out      = serial_out_q;
  assign bus.serial_wren_out = serial_wren_q;
  assign tx_state_dbg        = tx_state;

endmodule
